// File: rtl/tcb_lib_byteena2logsize.sv
// rtl/tcb_lib_byteena2logsize.sv - splits byte-enable requests into aligned log-size transfers
module tcb_lib_byteena2logsize #(
    parameter  int unsigned ADR_W   = 32,
    parameter  int unsigned BUS_BEN = 4,
    parameter  int unsigned STS_W   = 1,
    parameter  int unsigned HSK_DLY = 1,
    localparam int unsigned BUS_MAX = $clog2(BUS_BEN),
    localparam int unsigned SIZ_W   = $clog2(BUS_MAX + 1),
    localparam int unsigned DAT_W   = 8 * BUS_BEN
) (
    input  logic               clk,
    input  logic               rst,
    // byte-enable subordinate port
    input  logic               sub_vld_i,
    output logic               sub_rdy_o,
    input  logic               sub_req_ren_i,
    input  logic               sub_req_wen_i,
    input  logic [ADR_W-1:0]   sub_req_adr_i,
    input  logic [BUS_BEN-1:0] sub_req_ben_i,
    input  logic [DAT_W-1:0]   sub_req_wdt_i,
    output logic [DAT_W-1:0]   sub_rsp_rdt_o,
    output logic [STS_W-1:0]   sub_rsp_sts_o,
    // log-size manager port
    output logic               man_vld_o,
    input  logic               man_rdy_i,
    output logic               man_req_ren_o,
    output logic               man_req_wen_o,
    output logic [ADR_W-1:0]   man_req_adr_o,
    output logic [SIZ_W-1:0]   man_req_siz_o,
    output logic [DAT_W-1:0]   man_req_wdt_o,
    input  logic [DAT_W-1:0]   man_rsp_rdt_i,
    input  logic [STS_W-1:0]   man_rsp_sts_i
);

    localparam int unsigned OFF_W = BUS_MAX;
    // tracking entry: {vld, off, siz, last, nul}
    localparam int unsigned ENT_W = 3 + OFF_W + SIZ_W;
    localparam int unsigned TRK_W = (HSK_DLY == 0) ? ENT_W : HSK_DLY * ENT_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BUS_BEN-1:0] rem_q, rem_d;
    logic [DAT_W-1:0]   acc_q, acc_d;
    logic [STS_W-1:0]   sts_acc_q, sts_acc_d;

    logic [BUS_BEN-1:0] pnd;
    logic               nul;
    logic [OFF_W-1:0]   off;
    logic [SIZ_W-1:0]   siz;
    logic [BUS_BEN-1:0] cmask;
    logic [BUS_BEN-1:0] blk;
    logic               last;
    logic               man_hs;

    logic [ENT_W-1:0]   trk_d;
    logic [ENT_W-1:0]   trk_tail;
    logic               t_vld;
    logic [OFF_W-1:0]   t_off;
    logic [SIZ_W-1:0]   t_siz;
    logic               t_last;
    logic               t_nul;
    logic [DAT_W-1:0]   rmask;
    logic [DAT_W-1:0]   placed;
    logic [DAT_W-1:0]   merged;

    logic               adr_lo_unused;

    // mask covering the low 2**s bytes of the data bus
    function automatic logic [DAT_W-1:0] byte_mask(input logic [SIZ_W-1:0] s);
        return {DAT_W{1'b1}} >> (DAT_W - (8 << s));
    endfunction

    // the low address bits are replaced by the chunk offset
    assign adr_lo_unused = ^sub_req_adr_i[BUS_MAX-1:0];

    // a fresh request is split from its own enables, a split in progress from the remainder
    assign pnd = (state_q == ST_SPLIT) ? rem_q : sub_req_ben_i;
    assign nul = (state_q == ST_IDLE) && (sub_req_ben_i == '0);

    // chunk selection: lowest pending byte, then the largest aligned all-ones block there
    always_comb begin
        off   = '0;
        siz   = '0;
        blk   = '0;
        for (int i = BUS_BEN - 1; i >= 0; i--) begin
            if (pnd[OFF_W'(i)]) off = OFF_W'(i);
        end
        cmask = BUS_BEN'(1) << off;
        for (int s = 1; s <= BUS_MAX; s++) begin
            blk = ({BUS_BEN{1'b1}} >> (BUS_BEN - (1 << s))) << off;
            if (((32'(off) & ((1 << s) - 1)) == 0) &&
                (32'(off) + (1 << s) <= BUS_BEN) &&
                ((pnd & blk) == blk)) begin
                siz   = SIZ_W'(s);
                cmask = blk;
            end
        end
    end

    assign last   = ((pnd & ~cmask) == '0);
    assign man_hs = sub_vld_i & man_rdy_i;

    assign man_vld_o     = sub_vld_i;
    assign sub_rdy_o     = man_rdy_i & last;
    assign man_req_ren_o = sub_req_ren_i;
    assign man_req_wen_o = sub_req_wen_i & ~nul;
    assign man_req_adr_o = {sub_req_adr_i[ADR_W-1:BUS_MAX], off};
    assign man_req_siz_o = siz;
    assign man_req_wdt_o = (sub_req_wdt_i >> (8 * off)) & byte_mask(siz);

    // split state: advance the remainder on each accepted chunk, return to idle on the last one
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (man_hs) begin
            if (last) begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end else begin
                state_d = ST_SPLIT;
                rem_d   = pnd & ~cmask;
            end
        end
    end

    // split state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign trk_d = {man_hs, off, siz, last, nul};

    generate
        if (HSK_DLY == 0) begin : g_nodly
            assign trk_tail = trk_d;
        end else begin : g_dly
            logic [TRK_W-1:0] trk_q;

            // delay line matching the subordinate's fixed response delay
            always_ff @(posedge clk) begin
                if (rst) begin
                    trk_q <= '0;
                end else begin
                    trk_q <= (trk_q << ENT_W) | TRK_W'(trk_d);
                end
            end

            assign trk_tail = trk_q[TRK_W-1 -: ENT_W];
        end
    endgenerate

    assign t_nul  = trk_tail[0];
    assign t_last = trk_tail[1];
    assign t_siz  = trk_tail[2 +: SIZ_W];
    assign t_off  = trk_tail[2 + SIZ_W +: OFF_W];
    assign t_vld  = trk_tail[ENT_W-1];

    assign rmask  = byte_mask(t_siz) << (8 * t_off);
    assign placed = (man_rsp_rdt_i << (8 * t_off)) & rmask;
    assign merged = (acc_q & ~rmask) | placed;

    assign sub_rsp_rdt_o = (t_vld && t_last && !t_nul) ? merged : '0;
    assign sub_rsp_sts_o = (t_vld && t_last) ? (sts_acc_q | man_rsp_sts_i) : '0;

    // response merge: collect partial chunks, clear once the last chunk has been returned
    always_comb begin
        acc_d     = acc_q;
        sts_acc_d = sts_acc_q;
        if (t_vld) begin
            if (t_last) begin
                acc_d     = '0;
                sts_acc_d = '0;
            end else begin
                acc_d     = merged;
                sts_acc_d = sts_acc_q | man_rsp_sts_i;
            end
        end
    end

    // response accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sts_acc_q <= '0;
        end else begin
            acc_q     <= acc_d;
            sts_acc_q <= sts_acc_d;
        end
    end

endmodule

// File: tb/tb_tcb_lib_byteena2logsize.sv
// tb/tb_tcb_lib_byteena2logsize.sv - scoreboard bench for tcb_lib_byteena2logsize
module tb_tcb_lib_byteena2logsize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        sub_vld = 1'b0;
    logic        sub_rdy_o;
    logic        sub_req_ren = 1'b0;
    logic        sub_req_wen = 1'b0;
    logic [31:0] sub_req_adr = '0;
    logic [3:0]  sub_req_ben = '0;
    logic [31:0] sub_req_wdt = '0;
    logic [31:0] sub_rsp_rdt_o;
    logic [0:0]  sub_rsp_sts_o;

    logic        man_vld_o;
    logic        man_rdy = 1'b0;
    logic        man_req_ren_o;
    logic        man_req_wen_o;
    logic [31:0] man_req_adr_o;
    logic [1:0]  man_req_siz_o;
    logic [31:0] man_req_wdt_o;
    logic [31:0] man_rsp_rdt = '0;
    logic [0:0]  man_rsp_sts = '0;

    always #5 clk = ~clk;

    tcb_lib_byteena2logsize #(
        .ADR_W   (32),
        .BUS_BEN (4),
        .STS_W   (1),
        .HSK_DLY (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sub_vld_i     (sub_vld),
        .sub_rdy_o     (sub_rdy_o),
        .sub_req_ren_i (sub_req_ren),
        .sub_req_wen_i (sub_req_wen),
        .sub_req_adr_i (sub_req_adr),
        .sub_req_ben_i (sub_req_ben),
        .sub_req_wdt_i (sub_req_wdt),
        .sub_rsp_rdt_o (sub_rsp_rdt_o),
        .sub_rsp_sts_o (sub_rsp_sts_o),
        .man_vld_o     (man_vld_o),
        .man_rdy_i     (man_rdy),
        .man_req_ren_o (man_req_ren_o),
        .man_req_wen_o (man_req_wen_o),
        .man_req_adr_o (man_req_adr_o),
        .man_req_siz_o (man_req_siz_o),
        .man_req_wdt_o (man_req_wdt_o),
        .man_rsp_rdt_i (man_rsp_rdt),
        .man_rsp_sts_i (man_rsp_sts)
    );

    typedef struct {
        logic [31:0] adr;
        logic [1:0]  siz;
        logic        wen;
        logic        ren;
        logic [31:0] wdt;
        logic        last;
    } chunk_t;

    typedef struct {
        logic [31:0] rdt;
        logic        sts;
    } rsp_t;

    chunk_t      chunk_q[$];
    rsp_t        rsp_q[$];
    logic [7:0]  ref_mem[64];
    logic [7:0]  dev_mem[64];
    logic        err_map[64];
    int          errors = 0;
    int          checks = 0;
    int          rdy_pct = 100;

    chunk_t      mc;
    rsp_t        mr;
    int          midx;
    logic [31:0] nxt_rdt;
    logic        nxt_sts;
    bit          nxt_pend = 0;
    bit          sub_hs_prev = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // reference model: expected chunk list and merged response from the byte-enable rules
    task automatic plan(input logic [31:0] adr, input logic [3:0] ben, input logic wen,
                        input logic [31:0] wdt);
        logic [31:0] base;
        int          idx;
        int          p;
        int          o;
        int          n;
        chunk_t      c;
        rsp_t        r;
        base = adr & 32'hFFFF_FFFC;
        idx  = int'(base - 32'h100);
        r.rdt = '0;
        r.sts = 1'b0;
        if (ben == 4'b0000) begin
            c.adr  = base;
            c.siz  = 2'd0;
            c.wen  = 1'b0;
            c.ren  = ~wen;
            c.wdt  = {24'h0, wdt[7:0]};
            c.last = 1'b1;
            chunk_q.push_back(c);
            r.sts = err_map[idx];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ben[i]) begin
                    r.sts = r.sts | err_map[idx + i];
                    if (wen) ref_mem[idx + i] = wdt[8*i +: 8];
                    else     r.rdt[8*i +: 8] = ref_mem[idx + i];
                end
            end
            p = int'(ben);
            while (p != 0) begin
                o = 0;
                while (((p >> o) & 1) == 0) o++;
                n = 1;
                while ((o + 2 * n <= 4) && (o % (2 * n) == 0) &&
                       (((p >> o) & ((1 << (2 * n)) - 1)) == ((1 << (2 * n)) - 1)))
                    n = 2 * n;
                c.adr  = base + 32'(o);
                c.siz  = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
                c.wen  = wen;
                c.ren  = ~wen;
                c.wdt  = (wdt >> (8 * o)) & ((n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1));
                p      = p & ~(((1 << n) - 1) << o);
                c.last = (p == 0);
                chunk_q.push_back(c);
            end
        end
        rsp_q.push_back(r);
    endtask

    task automatic do_txn(input logic [31:0] adr, input logic [3:0] ben, input logic wen,
                          input logic [31:0] wdt, input bit abort);
        int cyc;
        plan(adr, ben, wen, wdt);
        sub_vld     = 1'b1;
        sub_req_adr = adr;
        sub_req_ben = ben;
        sub_req_wen = wen;
        sub_req_ren = ~wen;
        sub_req_wdt = wdt;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (abort ? (man_vld_o && man_rdy) : sub_rdy_o) break;
            cyc++;
            if (cyc > 200) begin
                fail_now("txn_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (abort) begin
            rst     = 1'b1;
            sub_vld = 1'b0;
            chunk_q.delete();
            rsp_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    // monitor: checks man requests and sub responses, and acts as the man-side memory
    always @(negedge clk) begin
        if (sub_hs_prev) begin
            if (rsp_q.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                mr = rsp_q.pop_front();
                check("sub_rsp_rdt", sub_rsp_rdt_o, mr.rdt);
                check("sub_rsp_sts", 32'(sub_rsp_sts_o), 32'(mr.sts));
            end
        end
        sub_hs_prev = !rst && sub_vld && sub_rdy_o;
        nxt_pend = 0;
        if (!rst && man_vld_o && man_rdy) begin
            if (chunk_q.size() == 0) begin
                fail_now("chunk_unexpected");
            end else begin
                mc = chunk_q.pop_front();
                check("man_adr", man_req_adr_o, mc.adr);
                check("man_siz", 32'(man_req_siz_o), 32'(mc.siz));
                check("man_wen", 32'(man_req_wen_o), 32'(mc.wen));
                check("man_ren", 32'(man_req_ren_o), 32'(mc.ren));
                check("man_wdt", man_req_wdt_o, mc.wdt);
                check("sub_rdy_last", 32'(sub_rdy_o), 32'(mc.last));
            end
            midx     = int'(man_req_adr_o[5:0]);
            nxt_pend = 1;
            nxt_sts  = 1'b0;
            nxt_rdt  = $urandom;
            for (int k = 0; k < (1 << man_req_siz_o); k++) begin
                nxt_sts = nxt_sts | err_map[(midx + k) & 63];
                if (man_req_wen_o) dev_mem[(midx + k) & 63] = man_req_wdt_o[8*k +: 8];
                else               nxt_rdt[8*k +: 8] = dev_mem[(midx + k) & 63];
            end
            if (man_req_wen_o) nxt_rdt = '0;
        end
    end

    // man-side subordinate: fixed one-cycle response, random ready, garbage when idle
    always @(posedge clk) begin
        #1;
        if (nxt_pend) begin
            man_rsp_rdt = nxt_rdt;
            man_rsp_sts = nxt_sts;
        end else begin
            man_rsp_rdt = $urandom;
            man_rsp_sts = 1'($urandom_range(1));
        end
        man_rdy = ($urandom_range(99) < rdy_pct);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
            err_map[i] = ($urandom_range(7) == 0);
        end
        for (int i = 0; i < 16; i++) err_map[i] = 1'b0;
        err_map[1] = 1'b1;
        ref_mem[4] = 8'h11; dev_mem[4] = 8'h11;
        ref_mem[6] = 8'h33; dev_mem[6] = 8'h33;
        ref_mem[7] = 8'h44; dev_mem[7] = 8'h44;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_man_vld", 32'(man_vld_o), 32'd0);
        check("reset_rsp_rdt", sub_rsp_rdt_o, 32'd0);
        check("reset_rsp_sts", 32'(sub_rsp_sts_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        rdy_pct = 100;
        do_txn(32'h100, 4'b1111, 1'b1, 32'hDDCC_BBAA, 0);
        do_txn(32'h100, 4'b1110, 1'b1, 32'hDDCC_BBAA, 0);
        rdy_pct = 40;
        do_txn(32'h104, 4'b1101, 1'b0, 32'h0, 0);
        rdy_pct = 100;
        do_txn(32'h102, 4'b0110, 1'b0, 32'h0, 0);
        do_txn(32'h100, 4'b0000, 1'b1, 32'h1234_5678, 0);

        do_txn(32'h108, 4'b0101, 1'b0, 32'h0, 1);
        @(negedge clk);
        check("abort_rsp_rdt", sub_rsp_rdt_o, 32'd0);
        check("abort_rsp_sts", 32'(sub_rsp_sts_o), 32'd0);
        check("abort_man_vld", 32'(man_vld_o), 32'd0);
        @(posedge clk);
        #1;
        do_txn(32'h108, 4'b0010, 1'b0, 32'h0, 0);

        for (int t = 0; t < 300; t++) begin
            rdy_pct = $urandom_range(100, 30);
            do_txn(32'h100 + 32'($urandom_range(63)), 4'($urandom_range(15)),
                   1'($urandom_range(1)), $urandom, 0);
            if ($urandom_range(3) == 0) begin
                sub_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        sub_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("chunk_q_drained", 32'(chunk_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
